// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vector_pkg
// Brief   : Shared opcode encoding and display-list entry geometry.
// Revision: 1.0 - initial release
// ============================================================================
package vector_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 2'b00,
        OP_MOVE = 2'b01,
        OP_DRAW = 2'b10,
        OP_END  = 2'b11
    } opcode_t;

    // Entry layout is {opcode, x, y}
    function automatic int entry_width(input int out_width);
        return OP_W + 2 * out_width;
    endfunction

    localparam int ENTRY_W = OP_W + 2 * 8;

endpackage
`default_nettype wire

// File: rtl/vector_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : vector_sequencer_if
// Brief   : Display-list read bus and line-drawer command bus.
// Revision: 1.0 - initial release
// ============================================================================
interface vector_sequencer_if #(
    parameter int OUT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 6
);
    import vector_pkg::*;

    logic [ADDR_WIDTH-1:0]               list_addr;
    logic [entry_width(OUT_WIDTH)-1:0]   list_data;
    logic [OUT_WIDTH-1:0]                x_start;
    logic [OUT_WIDTH-1:0]                y_start;
    logic [OUT_WIDTH-1:0]                x_end;
    logic [OUT_WIDTH-1:0]                y_end;
    logic                                pos;
    logic                                draw;
    logic                                draw_done;

    modport master (
        output list_addr, x_start, y_start, x_end, y_end, pos, draw,
        input  list_data, draw_done
    );

    modport slave (
        input  list_addr, x_start, y_start, x_end, y_end, pos, draw,
        output list_data, draw_done
    );

endinterface
`default_nettype wire

// File: rtl/vector_list_rom.sv
`default_nettype none
// ============================================================================
// Module  : vector_list_rom
// Brief   : Display-list store with one-cycle synchronous read and a load port.
// Revision: 1.0 - initial release
// ============================================================================
module vector_list_rom
    import vector_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = ENTRY_W
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_load_en,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0] i_load_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (i_load_en) begin
            r_mem[i_load_addr] <= i_load_data;
        end
        r_data <= r_mem[i_addr];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vector_sequencer
// Brief   : Walks a display list and issues MOVE/DRAW commands to a line drawer.
// Revision: 1.0 - initial release
// ============================================================================
module vector_sequencer
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FRAME_MIN  = 0,
    parameter int FRAME_MAX  = 255,
    parameter int POS_WAIT   = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enabled,
    input  logic frame_start,
    output logic busy,
    output logic frame_done,
    output logic err,
    vector_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_DECODE     = 3'd2;
    localparam logic [2:0] S_ISSUE_POS  = 3'd3;
    localparam logic [2:0] S_WAIT_POS   = 3'd4;
    localparam logic [2:0] S_ISSUE_DRAW = 3'd5;
    localparam logic [2:0] S_WAIT_DRAW  = 3'd6;
    localparam logic [2:0] S_FINISH     = 3'd7;

    localparam int c_entry_w = entry_width(OUT_WIDTH);
    localparam int c_tmax    = (TIMEOUT > POS_WAIT) ? TIMEOUT : POS_WAIT;
    localparam int c_timer_w = (c_tmax > 1) ? $clog2(c_tmax) : 1;
    localparam logic [OUT_WIDTH-1:0]  c_min       = OUT_WIDTH'(FRAME_MIN);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_timer_w-1:0]  r_timer;
    logic                  r_err;
    logic [OUT_WIDTH-1:0]  r_cur_x, r_cur_y;
    logic [OUT_WIDTH-1:0]  r_ent_x, r_ent_y;
    logic [OUT_WIDTH-1:0]  r_xs, r_ys, r_xe, r_ye;

    logic [OP_W-1:0]       w_op;
    logic [OUT_WIDTH-1:0]  w_x, w_y;
    logic                  w_last;
    logic                  w_pos_last;
    logic                  w_timeout;

    function automatic logic [OUT_WIDTH-1:0] clamp(input logic [OUT_WIDTH-1:0] v);
        logic [31:0] w_v;
        w_v = 32'(v);
        if (w_v < 32'(FRAME_MIN)) return OUT_WIDTH'(FRAME_MIN);
        if (w_v > 32'(FRAME_MAX)) return OUT_WIDTH'(FRAME_MAX);
        return v;
    endfunction

    assign w_op       = bus.list_data[c_entry_w-1 -: OP_W];
    assign w_x        = bus.list_data[2*OUT_WIDTH-1 -: OUT_WIDTH];
    assign w_y        = bus.list_data[OUT_WIDTH-1:0];
    // The last address finishes the frame instead of wrapping to 0
    assign w_last     = (r_addr == c_last_addr);
    assign w_pos_last = (POS_WAIT <= 1) || (r_timer == c_timer_w'(POS_WAIT - 1));
    assign w_timeout  = (r_timer == c_timer_w'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
            r_cur_x <= c_min;
            r_cur_y <= c_min;
            r_ent_x <= c_min;
            r_ent_y <= c_min;
            r_xs    <= c_min;
            r_ys    <= c_min;
            r_xe    <= c_min;
            r_ye    <= c_min;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start && enabled) begin
                        r_state <= S_FETCH;
                        r_addr  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_ent_x <= clamp(w_x);
                    r_ent_y <= clamp(w_y);
                    case (opcode_t'(w_op))
                        OP_NOP: begin
                            if (w_last) begin
                                r_state <= S_FINISH;
                            end else begin
                                r_addr  <= r_addr + ADDR_WIDTH'(1);
                                r_state <= S_FETCH;
                            end
                        end
                        OP_MOVE: begin
                            r_xe    <= clamp(w_x);
                            r_ye    <= clamp(w_y);
                            r_state <= S_ISSUE_POS;
                        end
                        OP_DRAW: begin
                            r_xs    <= r_cur_x;
                            r_ys    <= r_cur_y;
                            r_xe    <= clamp(w_x);
                            r_ye    <= clamp(w_y);
                            r_state <= S_ISSUE_DRAW;
                        end
                        default: r_state <= S_FINISH;
                    endcase
                end
                S_ISSUE_POS: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_POS;
                end
                S_WAIT_POS: begin
                    if (w_pos_last) begin
                        r_cur_x <= r_ent_x;
                        r_cur_y <= r_ent_y;
                        if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end
                S_ISSUE_DRAW: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_DRAW;
                end
                S_WAIT_DRAW: begin
                    // A timed-out line is treated as drawn so the frame still completes
                    if (bus.draw_done || w_timeout) begin
                        if (!bus.draw_done) r_err <= 1'b1;
                        r_cur_x <= r_ent_x;
                        r_cur_y <= r_ent_y;
                        if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.list_addr = r_addr;
    assign bus.x_start   = r_xs;
    assign bus.y_start   = r_ys;
    assign bus.x_end     = r_xe;
    assign bus.y_end     = r_ye;
    assign bus.pos       = (r_state == S_ISSUE_POS);
    assign bus.draw      = (r_state == S_ISSUE_DRAW);
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_FINISH);
    assign err           = r_err;

endmodule
`default_nettype wire
